mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the MEM/WB register.
- Drives a request/grant/rvalid data-memory bus and formats load data and store lanes.
- Stalls the upstream pipeline while an access is outstanding.
- Presents the wb_ctrl, read_data, result and rd values that MEM/WB captures.

Parameters:
- WIDTH, 32, data/address width (`WIDTH).
- R_WIDTH, 5, register index width (`R_WIDTH).
- WB_CTRL_WIDTH, 2, write-back control width (`WB_CTRL_WIDTH).
- TIMEOUT, 64, maximum cycles waited for dm_gnt_i or dm_rvalid_i before bus error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  EX/MEM slot holds a live instruction.
- mem_read_i  in  1  load.
- mem_write_i  in  1  store.
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word.
- mem_sign_i  in  1  sign-extend load data.
- wb_ctrl_i  in  WB_CTRL_WIDTH  write-back control from EX/MEM.
- result_i  in  WIDTH  ALU result; used as the address for loads and stores.
- store_data_i  in  WIDTH  store source register value.
- rd_i  in  R_WIDTH  destination register.
- dm_req_o  out  1  memory request.
- dm_we_o  out  1  write enable.
- dm_addr_o  out  WIDTH  word-aligned address.
- dm_be_o  out  4  byte enables.
- dm_wdata_o  out  WIDTH  lane-replicated store data.
- dm_gnt_i  in  1  request accepted.
- dm_rdata_i  in  WIDTH  read data.
- dm_rvalid_i  in  1  read data valid.
- stall_o  out  1  freeze PC, IF/ID and EX/MEM.
- misalign_o  out  1  one-cycle misaligned-access flag.
- bus_err_o  out  1  one-cycle timeout flag.
- wb_ctrl_o  out  WB_CTRL_WIDTH  to MEM/WB wb_ctrl_d.
- read_data_o  out  WIDTH  to MEM/WB read_data_d.
- result_o  out  WIDTH  to MEM/WB result_d.
- rd_o  out  R_WIDTH  to MEM/WB rd_d.

Behaviour:
- Interface fixed: one clock clk_i; rst_i is synchronous and active-high.
- FSM states: IDLE, REQ, RWAIT. A timeout counter of width clog2(TIMEOUT+1) is cleared on every state change.
- Reset state: state=IDLE, counter=0, misalign_o=0, bus_err_o=0. All combinational outputs derive from this state.
- Pass-through: result_o=result_i and rd_o=rd_i always.
- Bubble: wb_ctrl_o=0 whenever stall_o=1 or the instruction is suppressed.
- No memory op (valid_i & ~mem_read_i & ~mem_write_i): wb_ctrl_o=wb_ctrl_i, stall_o=0, zero latency.
- Misalignment check: half with addr[0]=1, or word with addr[1:0]!=0.
  - No request issued; misalign_o is high in the following cycle.
  - wb_ctrl_o=0 and stall_o=0 in the current cycle.
- IDLE with an aligned memory op:
  - dm_req_o=1 combinationally and stall_o=1.
  - Store and dm_gnt_i=1: stall_o=0, wb_ctrl_o=wb_ctrl_i; remain in IDLE.
  - Store without grant: go to REQ.
  - Load and dm_gnt_i=1: go to RWAIT.
  - Load without grant: go to REQ.
- REQ: hold dm_req_o and all bus fields stable until dm_gnt_i.
  - Store grant: complete exactly as in IDLE, return to IDLE.
  - Load grant: go to RWAIT.
- RWAIT: dm_req_o=0, stall_o=1 until dm_rvalid_i.
  - On rvalid: stall_o=0, read_data_o=formatted rdata, wb_ctrl_o=wb_ctrl_i; go to IDLE.
- Load latency: minimum 2 cycles (grant cycle plus rvalid cycle).
- Store data and enables:
  - Byte: be=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{sd[15:0]}}.
  - Word: be=1111.
- Load formatting: select the byte/half lane by addr[1:0]; sign- or zero-extend per mem_sign_i. Word loads pass through.
- dm_addr_o = {addr[WIDTH-1:2],2'b00}.
- Timeout: counter increments each cycle in REQ or RWAIT.
  - On reaching TIMEOUT: return to IDLE, bus_err_o=1 the next cycle, and drop the instruction (wb_ctrl_o=0, stall_o=0 that cycle).
  - rvalid or grant arriving in the timeout cycle wins; no error.
- dm_rvalid_i outside RWAIT is ignored.
- Reset mid-operation: next state is IDLE, dm_req_o=0, in-flight data discarded.

Decomposition:
- Shared package (global defines header):
  - `WIDTH, `R_WIDTH, `WB_CTRL_WIDTH.
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encodings.
- One combinational sub-module, mem_lane_fmt: store lane replication plus byte enables, and load extract/extend.

Test Plan:
- Word load addr 0x100, gnt in cycle 0, rvalid cycle 1 with rdata 0xDEADBEEF.
  - stall_o 1 then 0; read_data_o=0xDEADBEEF; wb_ctrl_o valid only in cycle 1.
- Signed byte load addr 0x103, rdata 0x80123456 -> read_data_o=0xFFFFFF80.
  - Same with mem_sign_i=0 -> 0x00000080.
- Store half addr 0x102, sd 0x00001234, gnt delayed 3 cycles.
  - dm_be_o=1100, dm_wdata_o=0x12341234, bus fields stable.
  - stall_o high for exactly 3 cycles.
- Word load addr 0x102 -> no dm_req_o, misalign_o=1 next cycle, wb_ctrl_o=0, stall_o=0.
- No rvalid for TIMEOUT cycles -> bus_err_o pulse, return to IDLE, stall released.
  - Repeat with rvalid exactly on the timeout cycle -> data accepted, no error.
- rst_i asserted in RWAIT, then a late rvalid -> state IDLE, dm_req_o=0, rvalid ignored, outputs at reset values.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, access-size
// encodings, FSM state encodings and the alignment check.
package mem_access_stage_pkg;

  localparam int unsigned MEM_WIDTH         = 32;
  localparam int unsigned MEM_R_WIDTH       = 5;
  localparam int unsigned MEM_WB_CTRL_WIDTH = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } sz_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    RWAIT = 2'b10
  } state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0. The unused size code
  // 2'b11 is handled like a word so it can never reach the bus unaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (sz_e'(size))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/rvalid bus.
//   master : driven by the MEM stage (request, write enable, address,
//            byte enables, write data); receives grant, read data, rvalid.
//   slave  : the memory side of the same bus.
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned WIDTH = MEM_WIDTH
);

  logic             dm_req_o;
  logic             dm_we_o;
  logic [WIDTH-1:0] dm_addr_o;
  logic [3:0]       dm_be_o;
  logic [WIDTH-1:0] dm_wdata_o;
  logic             dm_gnt_i;
  logic [WIDTH-1:0] dm_rdata_i;
  logic             dm_rvalid_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
    input  dm_gnt_i, dm_rdata_i, dm_rvalid_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
    output dm_gnt_i, dm_rdata_i, dm_rvalid_i
  );

endinterface

// File: rtl/mem_access_stage_lane_fmt.sv
// mem_lane_fmt: purely combinational lane handling for 32-bit memory.
//   size_i/sign_i/addr_lo_i : access size, sign-extend flag, address[1:0]
//   store_data_i            : store source value
//   rdata_i                 : raw word returned by memory
//   be_o / wdata_o          : byte enables and lane-replicated store data
//   load_data_o             : extracted and extended load value
module mem_lane_fmt
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned WIDTH = MEM_WIDTH
) (
  input  logic [1:0]       size_i,
  input  logic             sign_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [WIDTH-1:0] store_data_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [3:0]       be_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic [WIDTH-1:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (sz_e'(size_i))
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = WIDTH'({4{store_data_i[7:0]}});
        load_data_o = {{(WIDTH-8){sign_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = WIDTH'({2{store_data_i[15:0]}});
        load_data_o = {{(WIDTH-16){sign_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i .. rd_i     : EX/MEM slot contents (result_i is the address)
//   dm                  : data-memory bus (master side)
//   stall_o             : freezes PC, IF/ID and EX/MEM while an access is open
//   misalign_o          : one-cycle pulse after a rejected misaligned access
//   bus_err_o           : one-cycle pulse after a grant/rvalid timeout
//   wb_ctrl_o .. rd_o   : values captured by MEM/WB
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned WIDTH         = MEM_WIDTH,
  parameter int unsigned R_WIDTH       = MEM_R_WIDTH,
  parameter int unsigned WB_CTRL_WIDTH = MEM_WB_CTRL_WIDTH,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic [1:0]               mem_size_i,
  input  logic                     mem_sign_i,
  input  logic [WB_CTRL_WIDTH-1:0] wb_ctrl_i,
  input  logic [WIDTH-1:0]         result_i,
  input  logic [WIDTH-1:0]         store_data_i,
  input  logic [R_WIDTH-1:0]       rd_i,
  mem_access_stage_if.master       dm,
  output logic                     stall_o,
  output logic                     misalign_o,
  output logic                     bus_err_o,
  output logic [WB_CTRL_WIDTH-1:0] wb_ctrl_o,
  output logic [WIDTH-1:0]         read_data_o,
  output logic [WIDTH-1:0]         result_o,
  output logic [R_WIDTH-1:0]       rd_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;

  logic             mem_op;
  logic             req;
  logic             stall;
  logic             wb_pass;
  logic             load_done;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] load_data;

  assign mem_op = valid_i & (mem_read_i | mem_write_i);

  mem_lane_fmt #(
    .WIDTH (WIDTH)
  ) u_lane_fmt (
    .size_i       (mem_size_i),
    .sign_i       (mem_sign_i),
    .addr_lo_i    (result_i[1:0]),
    .store_data_i (store_data_i),
    .rdata_i      (dm.dm_rdata_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  // The EX/MEM slot is frozen by stall_o, so the bus fields computed from
  // it stay stable across REQ without extra holding registers. A timeout
  // completes the cycle with stall and write-back both low (instruction
  // dropped), while a grant/rvalid in that same cycle takes priority.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    req        = 1'b0;
    stall      = 1'b0;
    wb_pass    = 1'b0;
    load_done  = 1'b0;

    if (rst_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && !mem_op) begin
            wb_pass = 1'b1;
          end else if (mem_op) begin
            if (is_misaligned(mem_size_i, result_i[1:0])) begin
              misalign_d = 1'b1;
            end else begin
              req = 1'b1;
              if (mem_write_i) begin
                if (dm.dm_gnt_i) begin
                  wb_pass = 1'b1;
                end else begin
                  stall   = 1'b1;
                  state_d = REQ;
                end
              end else begin
                stall   = 1'b1;
                state_d = dm.dm_gnt_i ? RWAIT : REQ;
              end
            end
          end
        end

        REQ: begin
          req = 1'b1;
          if (dm.dm_gnt_i) begin
            if (mem_write_i) begin
              wb_pass = 1'b1;
              state_d = IDLE;
            end else begin
              stall   = 1'b1;
              state_d = RWAIT;
            end
          end else if (cnt_q == CNT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RWAIT: begin
          if (dm.dm_rvalid_i) begin
            wb_pass   = 1'b1;
            load_done = 1'b1;
            state_d   = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dm.dm_req_o   = req;
  assign dm.dm_we_o    = req & mem_write_i;
  assign dm.dm_addr_o  = req ? {result_i[WIDTH-1:2], 2'b00} : '0;
  assign dm.dm_be_o    = req ? be : '0;
  assign dm.dm_wdata_o = req ? wdata : '0;

  assign stall_o     = stall;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;
  assign wb_ctrl_o   = wb_pass ? wb_ctrl_i : '0;
  assign read_data_o = load_done ? load_data : '0;
  assign result_o    = result_i;
  assign rd_o        = rd_i;

endmodule
